// File: rtl/mult_seq_ctrl.sv
// Control sequencer for the shift-add signed multiplier.
// Edge-triggered start, fixed-latency load/add/shift strobes and a ready pulse.
module mult_seq_ctrl #(
  parameter int DW = 8,
  parameter int BW = $clog2(DW)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sign_mltnd,
  input  logic        sign_mlter,
  input  logic        lsb,
  output logic        load,
  output logic        clean,
  output logic        add_en,
  output logic        shift_en,
  output logic        ready,
  output logic        busy,
  output logic        final_sign,
  output logic [BW:0] count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    ADD_SHIFT = 3'd2
  } state_t;

  localparam logic [BW:0] LAST = (BW+1)'(DW - 1);

  state_t      state_q;
  state_t      state_n;
  logic [BW:0] count_n;
  logic        ready_n;
  logic        fsign_n;
  logic        start_q;
  logic        start_edge;

  assign start_edge = start & ~start_q;
  assign state      = state_q;

  // State, counter, ready pulse, result sign and start history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count      <= '0;
      ready      <= 1'b0;
      final_sign <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      count      <= count_n;
      ready      <= ready_n;
      final_sign <= fsign_n;
      start_q    <= start;
    end
  end

  // Next-state logic and strobes decoded from the current state
  always_comb begin
    state_n  = state_q;
    count_n  = count;
    ready_n  = 1'b0;
    fsign_n  = final_sign;
    load     = 1'b0;
    clean    = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        count_n = '0;
        if (start_edge && !abort) begin
          fsign_n = sign_mltnd ^ sign_mlter;
          state_n = INIT;
        end
      end
      INIT: begin
        load    = 1'b1;
        clean   = 1'b1;
        busy    = 1'b1;
        count_n = '0;
        if (abort) begin
          state_n = IDLE;
        end else begin
          state_n = ADD_SHIFT;
        end
      end
      ADD_SHIFT: begin
        shift_en = 1'b1;
        add_en   = lsb;
        busy     = 1'b1;
        if (abort) begin
          count_n = '0;
          state_n = IDLE;
        end else if (count == LAST) begin
          count_n = '0;
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: begin
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl.
// Checks strobes, latency, start edge handling, abort and async reset.
module tb_mult_seq_ctrl;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       start;
  logic       abort;
  logic       sign_mltnd;
  logic       sign_mlter;
  logic       lsb;
  logic       load;
  logic       clean;
  logic       add_en;
  logic       shift_en;
  logic       ready;
  logic       busy;
  logic       final_sign;
  logic [3:0] count;
  logic [2:0] state;

  int checks;
  int errors;
  int ready_cnt;
  logic [7:0] pat;

  mult_seq_ctrl #(.DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .sign_mltnd (sign_mltnd),
    .sign_mlter (sign_mlter),
    .lsb        (lsb),
    .load       (load),
    .clean      (clean),
    .add_en     (add_en),
    .shift_en   (shift_en),
    .ready      (ready),
    .busy       (busy),
    .final_sign (final_sign),
    .count      (count),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // {state, count, load, clean, add_en, shift_en, ready, busy, final_sign}
  function automatic logic [13:0] pk(
    input logic [2:0] st, input logic [3:0] cn,
    input logic ld, input logic cl, input logic ad, input logic sh,
    input logic rd, input logic bz, input logic fs);
    return {st, cn, ld, cl, ad, sh, rd, bz, fs};
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {state, count, load, clean, add_en, shift_en,
           ready, busy, final_sign};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag, input logic fs);
    chk(tag, pk(3'd0, 4'd0, 0, 0, 0, 0, 0, 0, fs));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sign_mltnd = 1'b0;
    sign_mlter = 1'b0;
    lsb = 1'b0;

    // 1: async reset with the clock stopped
    #7;
    rst = 1'b1;
    #1;
    idle_chk("rst_noclk", 1'b0);
    clk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    idle_chk("idle_after_rst", 1'b0);

    // 2: basic operation, signs 1,0, lsb 1,0,1,0,0,0,0,0
    pat = 8'b0000_0101;
    sign_mltnd = 1'b1;
    sign_mlter = 1'b0;
    start = 1'b1;
    step();
    chk("t2_init", pk(3'd1, 4'd0, 1, 1, 0, 0, 0, 1, 1));
    for (int i = 0; i < 8; i++) begin
      lsb = pat[i];
      step();
      chk($sformatf("t2_as%0d", i),
          pk(3'd2, 4'(i), 0, 0, pat[i], 1, 0, 1, 1));
    end
    lsb = 1'b0;
    step();
    chk("t2_ready", pk(3'd0, 4'd0, 0, 0, 0, 0, 1, 0, 1));

    // 3: start still held high; no second operation
    ready_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      step();
      if (ready) ready_cnt++;
      idle_chk("t3_hold", 1'b1);
    end
    checks++;
    assert (ready_cnt === 0) else begin
      errors++;
      $error("FAIL t3_extra_ready observed=%0d expected=0", ready_cnt);
    end
    start = 1'b0;
    step();

    // 4: start retoggled during ADD_SHIFT is ignored
    sign_mltnd = 1'b0;
    sign_mlter = 1'b0;
    start = 1'b1;
    step();
    chk("t4_init", pk(3'd1, 4'd0, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t4_as%0d", i),
          pk(3'd2, 4'(i), 0, 0, 0, 1, 0, 1, 0));
      if (i == 2) start = 1'b0;
      if (i == 3) start = 1'b1;
    end
    step();
    chk("t4_ready", pk(3'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0));
    start = 1'b0;
    step();
    idle_chk("t4_after", 1'b0);

    // 5: back-to-back start accepted in the ready cycle
    sign_mltnd = 1'b1;
    sign_mlter = 1'b0;
    start = 1'b1;
    step();
    chk("t5a_init", pk(3'd1, 4'd0, 1, 1, 0, 0, 0, 1, 1));
    start = 1'b0;
    lsb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t5a_as%0d", i),
          pk(3'd2, 4'(i), 0, 0, 1, 1, 0, 1, 1));
    end
    lsb = 1'b0;
    step();
    chk("t5a_ready", pk(3'd0, 4'd0, 0, 0, 0, 0, 1, 0, 1));
    sign_mltnd = 1'b1;
    sign_mlter = 1'b1;
    start = 1'b1;
    step();
    chk("t5b_init", pk(3'd1, 4'd0, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t5b_as%0d", i),
          pk(3'd2, 4'(i), 0, 0, 0, 1, 0, 1, 0));
    end
    step();
    chk("t5b_ready", pk(3'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0));
    start = 1'b0;
    step();

    // 6a: abort at count 4
    sign_mltnd = 1'b0;
    sign_mlter = 1'b1;
    start = 1'b1;
    step();
    chk("t6a_init", pk(3'd1, 4'd0, 1, 1, 0, 0, 0, 1, 1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t6a_as%0d", i),
          pk(3'd2, 4'(i), 0, 0, 0, 1, 0, 1, 1));
    end
    abort = 1'b1;
    step();
    chk("t6a_abort", pk(3'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1));
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      idle_chk("t6a_noready", 1'b1);
    end

    // abort wins over a start edge in IDLE
    start = 1'b0;
    step();
    sign_mltnd = 1'b1;
    sign_mlter = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    step();
    idle_chk("t6_abort_start", 1'b1);
    abort = 1'b0;
    step();
    idle_chk("t6_no_late_start", 1'b1);
    start = 1'b0;
    step();

    // 6b: async reset at count 4
    sign_mltnd = 1'b1;
    sign_mlter = 1'b0;
    start = 1'b1;
    step();
    chk("t6b_init", pk(3'd1, 4'd0, 1, 1, 0, 0, 0, 1, 1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t6b_as%0d", i),
          pk(3'd2, 4'(i), 0, 0, 0, 1, 0, 1, 1));
    end
    #2;
    rst = 1'b1;
    #1;
    idle_chk("t6b_rst_now", 1'b0);
    step();
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      idle_chk("t6b_noready", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
